// File: rtl/arb2_cfu.sv
// arb2_cfu -- two-initiator, one-target CFU-L2 request arbiter.
//
// Two CPU-side requesters (i0, i1) share one stateful CFU-L2 target.
// Request path: round-robin grant with a hold-until-accepted lock, zero
// added latency. Every accepted request pushes its initiator ID into an
// in-order FIFO. The target returns responses in request order, so the
// FIFO head steers each response back to its initiator.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. Once a valid is raised it is held, with
// its payload stable, until that transfer happens.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   iN_req_valid/ready          initiator N request handshake
//   iN_req_cfu/state/func/insn/data0/data1   initiator N request payload
//   iN_resp_valid/ready         initiator N response handshake
//   iN_resp_status/data         initiator N response payload
//   t_req_valid/ready           target request handshake
//   t_req_cfu/state/func/insn/data0/data1    target request payload
//   t_resp_valid/ready          target response handshake
//   t_resp_status/data          target response payload
//   dbg_fifo_count              number of requests in flight
//   dbg_lock                    grant currently held for an unaccepted request
//
// When INSN_W is 0 the insn field is absent: the insn ports are one bit
// wide, the inputs are ignored and t_req_insn is driven to 0.

module arb2_cfu #(
  parameter int CFU_ID_W     = 16,
  parameter int STATE_ID_W   = 1,
  parameter int FUNC_ID_W    = 10,
  parameter int INSN_W       = 0,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 4,
  localparam int INSN_PW     = (INSN_W > 0) ? INSN_W : 1,
  localparam int PTR_W       = $clog2(MAX_INFLIGHT),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i0_req_valid,
  output logic                  i0_req_ready,
  input  logic [CFU_ID_W-1:0]   i0_req_cfu,
  input  logic [STATE_ID_W-1:0] i0_req_state,
  input  logic [FUNC_ID_W-1:0]  i0_req_func,
  input  logic [INSN_PW-1:0]    i0_req_insn,
  input  logic [DATA_W-1:0]     i0_req_data0,
  input  logic [DATA_W-1:0]     i0_req_data1,
  output logic                  i0_resp_valid,
  input  logic                  i0_resp_ready,
  output logic [2:0]            i0_resp_status,
  output logic [DATA_W-1:0]     i0_resp_data,

  input  logic                  i1_req_valid,
  output logic                  i1_req_ready,
  input  logic [CFU_ID_W-1:0]   i1_req_cfu,
  input  logic [STATE_ID_W-1:0] i1_req_state,
  input  logic [FUNC_ID_W-1:0]  i1_req_func,
  input  logic [INSN_PW-1:0]    i1_req_insn,
  input  logic [DATA_W-1:0]     i1_req_data0,
  input  logic [DATA_W-1:0]     i1_req_data1,
  output logic                  i1_resp_valid,
  input  logic                  i1_resp_ready,
  output logic [2:0]            i1_resp_status,
  output logic [DATA_W-1:0]     i1_resp_data,

  output logic                  t_req_valid,
  input  logic                  t_req_ready,
  output logic [CFU_ID_W-1:0]   t_req_cfu,
  output logic [STATE_ID_W-1:0] t_req_state,
  output logic [FUNC_ID_W-1:0]  t_req_func,
  output logic [INSN_PW-1:0]    t_req_insn,
  output logic [DATA_W-1:0]     t_req_data0,
  output logic [DATA_W-1:0]     t_req_data1,
  input  logic                  t_resp_valid,
  output logic                  t_resp_ready,
  input  logic [2:0]            t_resp_status,
  input  logic [DATA_W-1:0]     t_resp_data,

  output logic [CNT_W-1:0]      dbg_fifo_count,
  output logic                  dbg_lock
);

  // Arbitration state
  logic rr_next_q, rr_next_d;
  logic lock_q, lock_d;
  logic locked_id_q, locked_id_d;

  // Order FIFO: one initiator-ID bit per slot
  logic [MAX_INFLIGHT-1:0] id_mem_q;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic grant;
  logic granted_valid;
  logic fifo_full;
  logic fifo_empty;
  logic req_hs;
  logic resp_hs;
  logic head_id;
  logic route_ok;

  // ---------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------
  always_comb begin
    if (lock_q)                            grant = locked_id_q;
    else if (i0_req_valid && !i1_req_valid) grant = 1'b0;
    else if (i1_req_valid && !i0_req_valid) grant = 1'b1;
    else                                   grant = rr_next_q;
  end

  // Full is taken from the registered count only: a pop in the same cycle
  // does not open a slot until the next cycle, keeping ready free of any
  // combinational path from the response side.
  assign fifo_full  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign fifo_empty = (count_q == '0);

  assign granted_valid = grant ? i1_req_valid : i0_req_valid;
  assign t_req_valid   = granted_valid & ~fifo_full & ~rst;
  assign i0_req_ready  = ~grant & t_req_ready & ~fifo_full & ~rst;
  assign i1_req_ready  =  grant & t_req_ready & ~fifo_full & ~rst;
  assign req_hs        = t_req_valid & t_req_ready;

  assign t_req_cfu   = grant ? i1_req_cfu   : i0_req_cfu;
  assign t_req_state = grant ? i1_req_state : i0_req_state;
  assign t_req_func  = grant ? i1_req_func  : i0_req_func;
  assign t_req_insn  = (INSN_W > 0) ? (grant ? i1_req_insn : i0_req_insn) : '0;
  assign t_req_data0 = grant ? i1_req_data0 : i0_req_data0;
  assign t_req_data1 = grant ? i1_req_data1 : i0_req_data1;

  // ---------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------
  assign head_id  = id_mem_q[rd_ptr_q];
  assign route_ok = ~fifo_empty & ~rst;

  assign i0_resp_valid  = route_ok & ~head_id & t_resp_valid;
  assign i1_resp_valid  = route_ok &  head_id & t_resp_valid;
  assign t_resp_ready   = route_ok & (head_id ? i1_resp_ready : i0_resp_ready);
  assign i0_resp_status = t_resp_status;
  assign i1_resp_status = t_resp_status;
  assign i0_resp_data   = t_resp_data;
  assign i1_resp_data   = t_resp_data;
  assign resp_hs        = t_resp_valid & t_resp_ready;

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    rr_next_d   = rr_next_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    if (req_hs) begin
      rr_next_d = ~grant;
      lock_d    = 1'b0;
    end else if (t_req_valid) begin
      // Offered but not taken: pin the grant so payload stays stable.
      lock_d      = 1'b1;
      locked_id_d = grant;
    end
  end

  // MAX_INFLIGHT is a power of two, so pointers wrap by overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(req_hs);
    rd_ptr_d = rd_ptr_q + PTR_W'(resp_hs);
    count_d  = count_q + CNT_W'(req_hs) - CNT_W'(resp_hs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_next_q   <= 1'b0;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      rr_next_q   <= rr_next_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Slot contents need no reset: a slot is only read after being written.
  always_ff @(posedge clk) begin
    if (req_hs) id_mem_q[wr_ptr_q] <= grant;
  end

  assign dbg_fifo_count = count_q;
  assign dbg_lock       = lock_q;

`ifndef SYNTHESIS
  // A target response with nothing in flight is dropped; flag it.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(t_resp_valid && fifo_empty));
`endif

endmodule

// File: tb/tb_arb2_cfu.sv
module tb_arb2_cfu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        i0_req_valid = 0, i1_req_valid = 0;
  logic        i0_req_ready, i1_req_ready;
  logic [15:0] i0_req_cfu = 16'h00A0, i1_req_cfu = 16'h00B1;
  logic [0:0]  i0_req_state = 1'b0, i1_req_state = 1'b1;
  logic [9:0]  i0_req_func = 10'h012, i1_req_func = 10'h02F;
  logic [0:0]  i0_req_insn = 1'b0, i1_req_insn = 1'b1;
  logic [31:0] i0_req_data0 = 0, i0_req_data1 = 0, i1_req_data0 = 0, i1_req_data1 = 0;
  logic        i0_resp_valid, i1_resp_valid;
  logic        i0_resp_ready = 1, i1_resp_ready = 1;
  logic [2:0]  i0_resp_status, i1_resp_status;
  logic [31:0] i0_resp_data, i1_resp_data;
  logic        t_req_valid;
  logic        t_req_ready = 1;
  logic [15:0] t_req_cfu;
  logic [0:0]  t_req_state;
  logic [9:0]  t_req_func;
  logic [0:0]  t_req_insn;
  logic [31:0] t_req_data0, t_req_data1;
  logic        t_resp_valid = 0;
  logic        t_resp_ready;
  logic [2:0]  t_resp_status = 0;
  logic [31:0] t_resp_data = 0;
  logic [2:0]  dbg_fifo_count;
  logic        dbg_lock;

  arb2_cfu dut (
    .clk(clk), .rst(rst),
    .i0_req_valid(i0_req_valid), .i0_req_ready(i0_req_ready),
    .i0_req_cfu(i0_req_cfu), .i0_req_state(i0_req_state), .i0_req_func(i0_req_func),
    .i0_req_insn(i0_req_insn), .i0_req_data0(i0_req_data0), .i0_req_data1(i0_req_data1),
    .i0_resp_valid(i0_resp_valid), .i0_resp_ready(i0_resp_ready),
    .i0_resp_status(i0_resp_status), .i0_resp_data(i0_resp_data),
    .i1_req_valid(i1_req_valid), .i1_req_ready(i1_req_ready),
    .i1_req_cfu(i1_req_cfu), .i1_req_state(i1_req_state), .i1_req_func(i1_req_func),
    .i1_req_insn(i1_req_insn), .i1_req_data0(i1_req_data0), .i1_req_data1(i1_req_data1),
    .i1_resp_valid(i1_resp_valid), .i1_resp_ready(i1_resp_ready),
    .i1_resp_status(i1_resp_status), .i1_resp_data(i1_resp_data),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
    .t_req_cfu(t_req_cfu), .t_req_state(t_req_state), .t_req_func(t_req_func),
    .t_req_insn(t_req_insn), .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
    .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
    .t_resp_status(t_resp_status), .t_resp_data(t_resp_data),
    .dbg_fifo_count(dbg_fifo_count), .dbg_lock(dbg_lock)
  );

  // ---------------- scoreboard / model state ----------------
  int unsigned total = 0;
  int unsigned bad   = 0;

  int          m_q[$];              // initiator IDs in flight, oldest first
  int          m_rr = 0;            // who wins the next tie
  int          m_lock = 0;          // an offer is outstanding
  int          m_lid = 0;           // initiator of the outstanding offer
  logic [31:0] t_pend[$];           // responses the target still owes
  logic [31:0] t_acc = 0;           // mulacc accumulator
  logic [31:0] exp_q0[$], exp_q1[$];
  int          grant_log[$];
  int          rid_log[$];
  logic [31:0] rdata0[$];
  logic        resp_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- target: latency-1 mulacc ----------------
  always @(posedge clk) begin
    #2;
    if (resp_en && t_pend.size() != 0) begin
      t_resp_valid  = 1'b1;
      t_resp_data   = t_pend[0];
      t_resp_status = t_pend[0][2:0];
    end else begin
      t_resp_valid  = 1'b0;
      t_resp_data   = 32'h0;
      t_resp_status = 3'h0;
    end
  end

  // ---------------- per-cycle model compare ----------------
  always @(negedge clk) begin : model
    int g, gv, full, empty, h, e_tv, e_r0, e_r1, e_rv0, e_rv1, e_trr, acc, pop, k;
    logic [31:0] d, e;
    if (rst) begin
      check("rst_t_req_valid", t_req_valid, 0);
      check("rst_i0_req_ready", i0_req_ready, 0);
      check("rst_i1_req_ready", i1_req_ready, 0);
      check("rst_i0_resp_valid", i0_resp_valid, 0);
      check("rst_i1_resp_valid", i1_resp_valid, 0);
      check("rst_t_resp_ready", t_resp_ready, 0);
      m_q.delete(); m_rr = 0; m_lock = 0; m_lid = 0;
      t_pend.delete(); t_acc = 0; exp_q0.delete(); exp_q1.delete();
    end else begin
      if (m_lock != 0)                         g = m_lid;
      else if (i0_req_valid && !i1_req_valid)  g = 0;
      else if (!i0_req_valid && i1_req_valid)  g = 1;
      else                                     g = m_rr;
      full  = (m_q.size() == 4);
      gv    = (g == 1) ? int'(i1_req_valid) : int'(i0_req_valid);
      e_tv  = (gv != 0 && full == 0);
      e_r0  = (g == 0 && t_req_ready && full == 0);
      e_r1  = (g == 1 && t_req_ready && full == 0);
      empty = (m_q.size() == 0);
      h     = (empty != 0) ? 0 : m_q[0];
      e_rv0 = (empty == 0 && h == 0 && t_resp_valid);
      e_rv1 = (empty == 0 && h == 1 && t_resp_valid);
      e_trr = (empty == 0 && ((h == 1) ? i1_resp_ready : i0_resp_ready));

      check("t_req_valid", t_req_valid, e_tv);
      check("i0_req_ready", i0_req_ready, e_r0);
      check("i1_req_ready", i1_req_ready, e_r1);
      check("i0_resp_valid", i0_resp_valid, e_rv0);
      check("i1_resp_valid", i1_resp_valid, e_rv1);
      check("t_resp_ready", t_resp_ready, e_trr);
      check("fifo_count", dbg_fifo_count, m_q.size());
      if (e_tv != 0) begin
        check("t_req_cfu",   t_req_cfu,   (g == 1) ? i1_req_cfu   : i0_req_cfu);
        check("t_req_state", t_req_state, (g == 1) ? i1_req_state : i0_req_state);
        check("t_req_func",  t_req_func,  (g == 1) ? i1_req_func  : i0_req_func);
        check("t_req_data0", t_req_data0, (g == 1) ? i1_req_data0 : i0_req_data0);
        check("t_req_data1", t_req_data1, (g == 1) ? i1_req_data1 : i0_req_data1);
        check("t_req_insn",  t_req_insn,  0);
      end

      acc = (e_tv != 0 && t_req_ready);
      pop = (t_resp_valid && e_trr != 0);
      if (pop != 0) begin
        k = m_q.pop_front();
        d = t_pend.pop_front();
        rid_log.push_back(k);
        if (k == 0) begin
          check("resp0_pending", exp_q0.size() != 0, 1);
          if (exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            check("resp0_data", i0_resp_data, e);
            check("resp0_status", i0_resp_status, e[2:0]);
          end
          rdata0.push_back(i0_resp_data);
        end else begin
          check("resp1_pending", exp_q1.size() != 0, 1);
          if (exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            check("resp1_data", i1_resp_data, e);
            check("resp1_status", i1_resp_status, e[2:0]);
          end
        end
      end
      if (acc != 0) begin
        m_q.push_back(g);
        m_rr = 1 - g;
        m_lock = 0;
        grant_log.push_back(g);
        t_acc += (g == 1) ? i1_req_data0 * i1_req_data1 : i0_req_data0 * i0_req_data1;
        t_pend.push_back(t_acc);
        if (g == 1) exp_q1.push_back(t_acc);
        else        exp_q0.push_back(t_acc);
      end else if (e_tv != 0) begin
        m_lock = 1;
        m_lid  = g;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; i0_req_valid = 0; i1_req_valid = 0; t_req_ready = 1;
    resp_en = 0; i0_resp_ready = 1; i1_resp_ready = 1;
    step(); step();
    rst = 0;
    grant_log.delete(); rid_log.delete(); rdata0.delete();
  endtask

  task automatic drain();
    i0_req_valid = 0; i1_req_valid = 0;
    resp_en = 1; i0_resp_ready = 1; i1_resp_ready = 1;
    for (int i = 0; i < 30 && (m_q.size() != 0 || t_pend.size() != 0); i++) step();
    check("drain_count", dbg_fifo_count, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("reset_count", dbg_fifo_count, 0);
    check("reset_lock", dbg_lock, 0);
    step();

    // 1: single initiator, mulacc 2*3 accumulating
    resp_en = 1;
    i0_req_data0 = 2; i0_req_data1 = 3; i0_req_valid = 1;
    step(); step(); step();
    i0_req_valid = 0;
    drain();
    check("t1_n_resp0", rdata0.size(), 3);
    check("t1_n_resp_total", rid_log.size(), 3);
    if (rdata0.size() == 3) begin
      check("t1_r0", rdata0[0], 6);
      check("t1_r1", rdata0[1], 12);
      check("t1_r2", rdata0[2], 18);
    end

    // 2: both valid continuously -> alternate 0,1,0,1
    do_reset();
    resp_en = 1;
    i0_req_data0 = 1; i0_req_data1 = 1; i1_req_data0 = 2; i1_req_data1 = 2;
    i0_req_valid = 1; i1_req_valid = 1;
    step(); step(); step(); step();
    i0_req_valid = 0; i1_req_valid = 0;
    drain();
    check("t2_n_grant", grant_log.size(), 4);
    check("t2_n_resp", rid_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size() && i < rid_log.size(); i++) begin
      check("t2_grant", grant_log[i], i % 2);
      check("t2_route", rid_log[i], i % 2);
    end
    check("t2_n_resp0", rdata0.size(), 2);
    if (rdata0.size() == 2) begin
      check("t2_r0", rdata0[0], 1);   // 1*1
      check("t2_r1", rdata0[1], 6);   // 1 + 4 + 1
    end

    // 3: target stalls 3 cycles with both valid
    do_reset();
    resp_en = 1;
    i0_req_data0 = 5; i0_req_data1 = 1; i1_req_data0 = 7; i1_req_data1 = 1;
    i0_req_valid = 1; i1_req_valid = 1; t_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_valid", t_req_valid, 1);
      check("t3_stall_data0", t_req_data0, 5);
      check("t3_stall_cfu", t_req_cfu, 16'h00A0);
      check("t3_stall_i1_ready", i1_req_ready, 0);
      if (i > 0) check("t3_lock", dbg_lock, 1);
      step();
    end
    t_req_ready = 1;
    @(negedge clk);
    check("t3_accept_i0", i0_req_ready, 1);
    check("t3_accept_data0", t_req_data0, 5);
    step();
    @(negedge clk);
    check("t3_next_i1", i1_req_ready, 1);
    check("t3_next_data0", t_req_data0, 7);
    step();
    drain();
    check("t3_n_grant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t3_g0", grant_log[0], 0);
      check("t3_g1", grant_log[1], 1);
    end

    // 4: fill to 4 in flight, 5th waits until the cycle after a pop
    do_reset();
    i0_req_data0 = 1; i0_req_data1 = 1; i0_req_valid = 1;
    step(); step(); step(); step();
    @(negedge clk);
    check("t4_full_count", dbg_fifo_count, 4);
    check("t4_full_valid", t_req_valid, 0);
    check("t4_full_ready", i0_req_ready, 0);
    step();
    resp_en = 1;
    @(negedge clk);
    check("t4_pop_resp_ready", t_resp_ready, 1);
    check("t4_pop_same_valid", t_req_valid, 0);
    check("t4_pop_same_ready", i0_req_ready, 0);
    step();
    resp_en = 0;
    @(negedge clk);
    check("t4_after_count", dbg_fifo_count, 3);
    check("t4_after_valid", t_req_valid, 1);
    check("t4_after_ready", i0_req_ready, 1);
    step();
    i0_req_valid = 0;
    drain();
    check("t4_n_grant", grant_log.size(), 5);

    // 5: response backpressure with head = i1
    do_reset();
    i1_req_data0 = 3; i1_req_data1 = 3; i1_req_valid = 1;
    step();
    i1_req_valid = 0; i1_resp_ready = 0; resp_en = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_bp_resp_ready", t_resp_ready, 0);
      check("t5_bp_count", dbg_fifo_count, 1);
      check("t5_bp_i1_valid", i1_resp_valid, 1);
      check("t5_bp_i0_valid", i0_resp_valid, 0);
      step();
    end
    i1_resp_ready = 1;
    @(negedge clk);
    check("t5_rel_resp_ready", t_resp_ready, 1);
    check("t5_rel_data", i1_resp_data, 9);
    step();
    check("t5_done_count", dbg_fifo_count, 0);
    drain();

    // 6: reset with 2 in flight, rr_next left at 1 beforehand
    do_reset();
    i0_req_data0 = 3; i0_req_data1 = 1; i0_req_valid = 1;
    step(); step();
    rst = 1;
    i1_req_valid = 1; i1_req_data0 = 9; i1_req_data1 = 1; resp_en = 1;
    @(negedge clk);
    check("t6_rst_t_valid", t_req_valid, 0);
    check("t6_rst_i0_ready", i0_req_ready, 0);
    check("t6_rst_resp_valid", i0_resp_valid, 0);
    step();
    @(negedge clk);
    check("t6_rst_count", dbg_fifo_count, 0);
    check("t6_rst_lock", dbg_lock, 0);
    step();
    rst = 0;
    @(negedge clk);
    check("t6_post_i0_ready", i0_req_ready, 1);
    check("t6_post_i1_ready", i1_req_ready, 0);
    check("t6_post_data0", t_req_data0, 3);
    step();
    drain();

    check("final_exp0_empty", exp_q0.size(), 0);
    check("final_exp1_empty", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
